// File: rtl/fir_sched.sv
// fir_sched: ring-buffer FIR sequencer (write sample, read M taps newest-first, MAC, output).
// Optional macro FIR_SAT_EN: clamp the shifted accumulator instead of wrapping it.
module fir_sched #(
    parameter int M         = 23,
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 16,
    parameter int COEF_SIZE = 16,
    parameter int SHIFT     = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [DATA_SIZE-1:0] di,
    output logic                        ready,
    output logic                        done,
    output logic signed [DATA_SIZE-1:0] filt_out,
    output logic                        bram_en,
    output logic                        bram_we,
    output logic        [ADDR_SIZE-1:0] bram_addr,
    output logic signed [DATA_SIZE-1:0] bram_do,
    input  logic signed [DATA_SIZE-1:0] bram_di,
    output logic        [ADDR_SIZE-1:0] coef_addr,
    input  logic signed [COEF_SIZE-1:0] coef_di
);
    localparam int PROD_W = DATA_SIZE + COEF_SIZE;
    localparam int ACC_W  = PROD_W + ADDR_SIZE;
    localparam int CNT_W  = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(M - 1);
    localparam logic [CNT_W-1:0]     TAPS = CNT_W'(M);
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
`endif

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN, DONE} state_t;

    state_t                      state;
    logic        [ADDR_SIZE-1:0] head;
    logic        [ADDR_SIZE-1:0] rd_ptr;
    logic        [CNT_W-1:0]     fill;
    logic        [CNT_W-1:0]     k;
    logic                        vld_p0, mask_p0;
    logic                        vld_p1, mask_p1;
    logic signed [PROD_W-1:0]    prod_p1;
    logic signed [ACC_W-1:0]     acc;

    function automatic logic [ADDR_SIZE-1:0] ptr_dec(input logic [ADDR_SIZE-1:0] p);
        return (p == '0) ? LAST : p - ADDR_SIZE'(1);
    endfunction

    function automatic logic signed [DATA_SIZE-1:0] reduce(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_MAX) return {1'b0, {(DATA_SIZE-1){1'b1}}};
        if (s < SAT_MIN) return {1'b1, {(DATA_SIZE-1){1'b0}}};
        return s[DATA_SIZE-1:0];
`else
        return DATA_SIZE'(a >>> SHIFT);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            filt_out  <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_do   <= '0;
            coef_addr <= '0;
            head      <= '0;
            fill      <= '0;
            k         <= '0;
            rd_ptr    <= '0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ready     <= 1'b0;
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= head;
                        bram_do   <= di;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    // tap 0 reads back the sample just written
                    bram_we   <= 1'b0;
                    bram_addr <= head;
                    rd_ptr    <= ptr_dec(head);
                    coef_addr <= '0;
                    k         <= CNT_W'(1);
                    vld_p0    <= 1'b1;
                    state     <= READ;
                end
                READ: begin
                    if (k == TAPS) begin
                        bram_en <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        bram_addr <= rd_ptr;
                        rd_ptr    <= ptr_dec(rd_ptr);
                        coef_addr <= k[ADDR_SIZE-1:0];
                        k         <= k + CNT_W'(1);
                        vld_p0    <= 1'b1;
                    end
                end
                DRAIN: state <= FIN;
                FIN: begin
                    filt_out <= reduce(acc);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    head  <= (head == LAST) ? '0 : head + ADDR_SIZE'(1);
                    if (fill != TAPS) fill <= fill + CNT_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p0: read issued; taps beyond the samples accepted so far are masked
    always_ff @(posedge clk) begin
        mask_p0 <= (state == READ) && (k > fill);
    end

    // p1: BRAM data and coefficient are present
    always_ff @(posedge clk) begin
        mask_p1 <= mask_p0;
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    assign prod_p1 = PROD_W'(bram_di) * PROD_W'(coef_di);

    always_ff @(posedge clk) begin
        if (rst)                       acc <= '0;
        else if (state == IDLE && start) acc <= '0;
        else if (vld_p1 && !mask_p1)   acc <= acc + ACC_W'(prod_p1);
    end
endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: directed cases plus random samples against a tap-history reference model.
module tb_fir_sched;
    localparam int M  = 4;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int SH = 0;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic signed [DW-1:0] di;
    logic                 ready, done;
    logic signed [DW-1:0] filt_out;
    logic                 bram_en, bram_we;
    logic        [AW-1:0] bram_addr;
    logic signed [DW-1:0] bram_do;
    logic signed [DW-1:0] bram_di;
    logic        [AW-1:0] coef_addr;
    logic signed [CW-1:0] coef_di;

    fir_sched #(.M(M), .ADDR_SIZE(AW), .DATA_SIZE(DW), .COEF_SIZE(CW), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .start(start), .di(di), .ready(ready), .done(done),
        .filt_out(filt_out), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_do(bram_do), .bram_di(bram_di), .coef_addr(coef_addr), .coef_di(coef_di)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem  [0:(1<<AW)-1];
    logic signed [CW-1:0] crom [0:(1<<AW)-1];
    int wr_a[$], wr_d[$], rd_a[$];

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_do;
            else         bram_di <= mem[bram_addr];
        end
        coef_di <= crom[coef_addr];
    end

    always @(posedge clk) begin
        if (bram_en && bram_we) begin
            wr_a.push_back(int'(bram_addr));
            wr_d.push_back(int'(bram_do));
        end
        if (bram_en && !bram_we) rd_a.push_back(int'(bram_addr));
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: newest-first history of at most M samples, dot product with coefficients.
    int hist[$];
    int coefs[M];
    int exp_head;

    function automatic longint model_out();
        longint a;
        logic signed [DW-1:0] t;
        a = 0;
        for (int i = 0; i < hist.size(); i++) a += longint'(hist[i]) * longint'(coefs[i]);
        a = a >>> SH;
`ifdef FIR_SAT_EN
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        return a;
`else
        t = DW'(a);
        return longint'(t);
`endif
    endfunction

    task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < M; i++) begin
            coefs[i] = c[i];
            crom[i]  = CW'(c[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        exp_head = 0;
    endtask

    task automatic run_sample(input int x, input bit pulse, output longint got);
        int n;
        bit early_ready;
        longint e;
        @(negedge clk);
        n = 0;
        while (!ready && n < 4*M + 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_idle", ready, 1);
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        di = DW'(x);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        early_ready = 1'b0;
        n = 0;
        while (n < M + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (pulse) start = (n == 3);
            if (done) break;
            if (ready) early_ready = 1'b1;
        end
        start = 1'b0;
        chk("latency", n, M + 3);
        chk("ready_low_busy", early_ready, 0);
        got = filt_out;
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("ready_back", ready, 1);
        hist.push_front(x);
        if (hist.size() > M) void'(hist.pop_back());
        e = model_out();
        chk("filt_out", got, e);
        chk("wr_count", wr_a.size(), 1);
        chk("wr_addr", wr_a.size() > 0 ? wr_a[0] : -1, exp_head);
        chk("wr_data", wr_d.size() > 0 ? wr_d[0] : 99999, x);
        chk("rd_count", rd_a.size(), M);
        for (int k = 0; k < M; k++)
            chk("rd_addr", k < rd_a.size() ? rd_a[k] : -1, (exp_head - k + M) % M);
        exp_head = (exp_head + 1) % M;
    endtask

    int exp_sum[5] = '{10, 30, 60, 100, 140};
    int exp_imp[5] = '{3000, -2000, 5000, 1000, 0};

    initial begin
        longint got;
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        di = '0;
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]  = DW'($urandom);
            crom[i] = '0;
        end
        hist.delete();
        exp_head = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_filt_out", filt_out, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_do", bram_do, 0);
        chk("rst_coef_addr", coef_addr, 0);
        rst = 1'b0;

        // Running sum with unit coefficients
        set_coef(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            run_sample(10 * (i + 1), 1'b0, got);
            chk("sum_out", got, exp_sum[i]);
        end
        chk("sum_rd5_k1", rd_a.size() > 1 ? rd_a[1] : -1, 3);

        // Impulse response
        do_reset();
        set_coef(3, -2, 5, 1);
        for (int i = 0; i < 5; i++) begin
            run_sample(i == 0 ? 1000 : 0, 1'b0, got);
            chk("impulse_out", got, exp_imp[i]);
        end

        // start while busy is dropped
        run_sample(123, 1'b1, got);
        cnt = 0;
        repeat (3*M + 8) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("busy_no_extra_done", cnt, 0);
        run_sample(-77, 1'b0, got);

        // Full-scale accumulation
        do_reset();
        set_coef(32767, 32767, 32767, 32767);
        for (int i = 0; i < 4; i++) run_sample(32767, 1'b0, got);
`ifdef FIR_SAT_EN
        chk("sat_out", got, 32767);
`else
        chk("wrap_out", got, 4);
`endif

        // Abort during READ
        set_coef(7, 11, 13, 17);
        @(negedge clk);
        di = DW'(500);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_bram_en", bram_en, 0);
        chk("abort_filt_out", filt_out, 0);
        rst = 1'b0;
        hist.delete();
        exp_head = 0;
        cnt = 0;
        repeat (3*M + 8) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_sample(-321, 1'b0, got);
        chk("abort_fill1", got, -321 * 7);

        // Random samples and coefficients
        do_reset();
        set_coef(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 20; i++)
            run_sample(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 3) == 0), got);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
